// File: rtl/dot_frame_buffer_pkg.sv
// Shared sizing constants, FSM encoding and coordinate clamp helpers
// for the dot frame buffer and its hit comparator.
package dot_frame_buffer_pkg;

    localparam int NUM_DOTS  = 20;
    localparam int IDX_WIDTH = 5;
    localparam int X_WIDTH   = 10;
    localparam int Y_WIDTH   = 9;
    localparam int X_MAX     = 639;
    localparam int Y_MAX     = 479;
    localparam int X_INIT    = 320;
    localparam int Y_INIT    = 240;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_COPY    = 2'd2
    } state_e;

    function automatic logic [X_WIDTH-1:0] clamp_x(input logic [X_WIDTH-1:0] v);
        return (v > X_WIDTH'(X_MAX)) ? X_WIDTH'(X_MAX) : v;
    endfunction

    function automatic logic [Y_WIDTH-1:0] clamp_y(input logic [Y_WIDTH-1:0] v);
        return (v > Y_WIDTH'(Y_MAX)) ? Y_WIDTH'(Y_MAX) : v;
    endfunction

endpackage

// File: rtl/dot_hit_compare.sv
// Combinational match of the current pixel against every active dot;
// duplicates collapse into a single hit through the OR-reduction.
module dot_hit_compare
    import dot_frame_buffer_pkg::*;
(
    input  logic [X_WIDTH-1:0]               i_x,
    input  logic [Y_WIDTH-1:0]               i_y,
    input  logic [NUM_DOTS-1:0][X_WIDTH-1:0] i_dot_x,
    input  logic [NUM_DOTS-1:0][Y_WIDTH-1:0] i_dot_y,
    output logic                             o_hit
);

    logic [NUM_DOTS-1:0] w_match;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DOTS; gi++) begin : g_cmp
            assign w_match[gi] = (i_x == i_dot_x[gi]) && (i_y == i_dot_y[gi]);
        end
    endgenerate

    assign o_hit = |w_match;

endmodule

// File: rtl/dot_frame_buffer.sv
// Shadow/active dot tables with a frame-synchronous atomic publish,
// per-pixel hit output and processor status flags.
module dot_frame_buffer
    import dot_frame_buffer_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dots_wren,
    input  logic [IDX_WIDTH-1:0] dot_num,
    input  logic                 is_x_change,
    input  logic [X_WIDTH-1:0]   dot_pos_change,
    input  logic                 commit,
    input  logic                 screenEnd,
    input  logic [X_WIDTH-1:0]   x,
    input  logic [Y_WIDTH-1:0]   y,
    output logic                 is_dot,
    output logic                 busy,
    output logic                 frame_tick,
    output logic                 commit_done,
    output logic                 wr_err
);

    state_e r_state;
    state_e w_state_next;
    logic   r_screen_q;
    logic   r_busy;
    logic   r_frame_tick;
    logic   r_commit_done;
    logic   r_wr_err;
    logic   r_is_dot;

    logic                             w_edge;
    logic                             w_idx_ok;
    logic                             w_over;
    logic                             w_wr_ok;
    logic                             w_wr_err;
    logic                             w_copy;
    logic                             w_hit;
    logic [Y_WIDTH-1:0]               w_y_in;
    logic [X_WIDTH-1:0]               w_x_val;
    logic [Y_WIDTH-1:0]               w_y_val;
    logic [NUM_DOTS-1:0][X_WIDTH-1:0] w_active_x;
    logic [NUM_DOTS-1:0][Y_WIDTH-1:0] w_active_y;

    assign w_edge   = screenEnd & ~r_screen_q;
    assign w_copy   = (r_state == ST_COPY);
    assign w_idx_ok = (dot_num < IDX_WIDTH'(NUM_DOTS));
    assign w_y_in   = dot_pos_change[Y_WIDTH-1:0];
    assign w_over   = is_x_change ? (dot_pos_change > X_WIDTH'(X_MAX))
                                  : (w_y_in > Y_WIDTH'(Y_MAX));
    assign w_wr_ok  = dots_wren & w_idx_ok & ~r_busy;
    assign w_wr_err = dots_wren & (~w_idx_ok | r_busy | w_over);
    assign w_x_val  = clamp_x(dot_pos_change);
    assign w_y_val  = clamp_y(w_y_in);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (commit) w_state_next = w_edge ? ST_COPY : ST_PENDING;
            ST_PENDING: if (w_edge) w_state_next = ST_COPY;
            ST_COPY:    w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // busy tracks the next state so it equals (state != IDLE) every cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_screen_q    <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_tick  <= 1'b0;
            r_commit_done <= 1'b0;
            r_wr_err      <= 1'b0;
            r_is_dot      <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_screen_q    <= screenEnd;
            r_busy        <= (w_state_next != ST_IDLE);
            r_frame_tick  <= w_edge;
            r_commit_done <= w_copy;
            r_is_dot      <= w_hit;
            if (w_wr_err)
                r_wr_err <= 1'b1;
            else if (w_copy)
                r_wr_err <= 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DOTS; gi++) begin : g_dot
            logic [X_WIDTH-1:0] r_shadow_x;
            logic [Y_WIDTH-1:0] r_shadow_y;
            logic [X_WIDTH-1:0] r_active_x;
            logic [Y_WIDTH-1:0] r_active_y;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_shadow_x <= X_WIDTH'(X_INIT);
                    r_shadow_y <= Y_WIDTH'(Y_INIT);
                    r_active_x <= X_WIDTH'(X_INIT);
                    r_active_y <= Y_WIDTH'(Y_INIT);
                end else begin
                    if (w_wr_ok && (dot_num == IDX_WIDTH'(gi))) begin
                        if (is_x_change)
                            r_shadow_x <= w_x_val;
                        else
                            r_shadow_y <= w_y_val;
                    end
                    if (w_copy) begin
                        r_active_x <= r_shadow_x;
                        r_active_y <= r_shadow_y;
                    end
                end
            end

            assign w_active_x[gi] = r_active_x;
            assign w_active_y[gi] = r_active_y;
        end
    endgenerate

    dot_hit_compare u_hit (
        .i_x     (x),
        .i_y     (y),
        .i_dot_x (w_active_x),
        .i_dot_y (w_active_y),
        .o_hit   (w_hit)
    );

    assign is_dot      = r_is_dot;
    assign busy        = r_busy;
    assign frame_tick  = r_frame_tick;
    assign commit_done = r_commit_done;
    assign wr_err      = r_wr_err;

endmodule

// File: tb/tb_dot_frame_buffer.sv
// Bench for dot_frame_buffer: a constant vector table, directed multi-cycle
// sequences and randomized traffic against a transaction-level table model.
module tb_dot_frame_buffer;

    logic       clk;
    logic       reset;
    logic       dots_wren;
    logic [4:0] dot_num;
    logic       is_x_change;
    logic [9:0] dot_pos_change;
    logic       commit;
    logic       screenEnd;
    logic [9:0] x;
    logic [8:0] y;
    logic       is_dot;
    logic       busy;
    logic       frame_tick;
    logic       commit_done;
    logic       wr_err;

    int total;
    int bad;
    int cyc;

    dot_frame_buffer dut (
        .clk            (clk),
        .reset          (reset),
        .dots_wren      (dots_wren),
        .dot_num        (dot_num),
        .is_x_change    (is_x_change),
        .dot_pos_change (dot_pos_change),
        .commit         (commit),
        .screenEnd      (screenEnd),
        .x              (x),
        .y              (y),
        .is_dot         (is_dot),
        .busy           (busy),
        .frame_tick     (frame_tick),
        .commit_done    (commit_done),
        .wr_err         (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Tables plus "a publish has been requested" and "publish happens now".
    int m_sx[20], m_sy[20], m_ax[20], m_ay[20];
    bit m_pending, m_copy_due, m_err, m_prev_se;
    bit e_hit, e_busy, e_ft, e_cd;

    task automatic model_reset();
        for (int i = 0; i < 20; i++) begin
            m_sx[i] = 320; m_sy[i] = 240; m_ax[i] = 320; m_ay[i] = 240;
        end
        m_pending = 0; m_copy_due = 0; m_err = 0; m_prev_se = 0;
    endtask

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, got, want);
        end
    endtask

    // One clock: predict from the inputs now applied, clock, then compare.
    task automatic tick();
        bit edge_s, mbusy, idx_ok, over, err, acc;
        int yv, nv;
        edge_s = screenEnd && !m_prev_se;
        mbusy  = m_pending || m_copy_due;
        e_ft   = edge_s;
        e_cd   = m_copy_due;
        e_hit  = 0;
        for (int i = 0; i < 20; i++)
            if (int'(x) == m_ax[i] && int'(y) == m_ay[i]) e_hit = 1;
        idx_ok = (int'(dot_num) < 20);
        yv     = int'(dot_pos_change) % 512;
        over   = is_x_change ? (int'(dot_pos_change) > 639) : (yv > 479);
        err    = dots_wren && (!idx_ok || mbusy || over);
        acc    = dots_wren && idx_ok && !mbusy;
        if (err) m_err = 1;
        else if (m_copy_due) m_err = 0;
        if (m_copy_due) begin
            for (int i = 0; i < 20; i++) begin
                m_ax[i] = m_sx[i]; m_ay[i] = m_sy[i];
            end
            m_copy_due = 0;
        end else if (m_pending) begin
            if (edge_s) begin m_pending = 0; m_copy_due = 1; end
        end else if (commit) begin
            if (edge_s) m_copy_due = 1; else m_pending = 1;
        end
        if (acc) begin
            if (is_x_change) begin
                nv = (int'(dot_pos_change) > 639) ? 639 : int'(dot_pos_change);
                m_sx[dot_num] = nv;
            end else begin
                nv = (yv > 479) ? 479 : yv;
                m_sy[dot_num] = nv;
            end
        end
        m_prev_se = screenEnd;
        e_busy = m_pending || m_copy_due;
        @(posedge clk); #1;
        cyc++;
        chk("is_dot", is_dot, e_hit);
        chk("busy", busy, e_busy);
        chk("frame_tick", frame_tick, e_ft);
        chk("commit_done", commit_done, e_cd);
        chk("wr_err", wr_err, m_err);
    endtask

    task automatic wr(input int num, input bit isx, input int pos);
        dots_wren = 1; dot_num = 5'(num); is_x_change = isx; dot_pos_change = 10'(pos);
        tick();
        dots_wren = 0;
    endtask

    task automatic clear_inputs();
        dots_wren = 0; dot_num = '0; is_x_change = 0; dot_pos_change = '0;
        commit = 0; screenEnd = 0; x = '0; y = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
    endtask

    // ---------------- constant vector table ----------------
    typedef struct {
        logic       wren;
        logic [4:0] num;
        logic       isx;
        logic [9:0] pos;
        logic       cm;
        logic       se;
        logic [9:0] px;
        logic [8:0] py;
        logic       e_hit, e_busy, e_ft, e_cd, e_err;
    } vec_t;

    function automatic vec_t mk(input int wren, input int num, input int isx, input int pos,
                                input int cm, input int se, input int px, input int py,
                                input int hit, input int bz, input int ft, input int cd,
                                input int er);
        vec_t v;
        v.wren = wren[0]; v.num = num[4:0]; v.isx = isx[0]; v.pos = pos[9:0];
        v.cm = cm[0]; v.se = se[0]; v.px = px[9:0]; v.py = py[8:0];
        v.e_hit = hit[0]; v.e_busy = bz[0]; v.e_ft = ft[0]; v.e_cd = cd[0]; v.e_err = er[0];
        return v;
    endfunction

    vec_t vecs[12];

    int ft_cnt, cd_cnt, ft_idx, cd_idx;

    initial begin
        total = 0; bad = 0; cyc = 0;
        //               wr num isx pos cm se  px  py  hit bz ft cd er
        vecs[0]  = mk(0, 0, 0, 0,   0, 0, 320, 240, 1, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0,   0, 0, 321, 240, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 3, 1, 100, 0, 0, 100, 50,  0, 0, 0, 0, 0);
        vecs[3]  = mk(1, 3, 0, 50,  0, 0, 100, 50,  0, 0, 0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0,   1, 0, 100, 50,  0, 1, 0, 0, 0);
        vecs[5]  = mk(1, 0, 1, 10,  0, 0, 100, 50,  0, 1, 0, 0, 1);
        vecs[6]  = mk(1, 25, 1, 5,  0, 0, 100, 50,  0, 1, 0, 0, 1);
        vecs[7]  = mk(0, 0, 0, 0,   0, 1, 100, 50,  0, 1, 1, 0, 1);
        vecs[8]  = mk(0, 0, 0, 0,   0, 1, 100, 50,  0, 0, 0, 1, 0);
        vecs[9]  = mk(0, 0, 0, 0,   0, 0, 100, 50,  1, 0, 0, 0, 0);
        vecs[10] = mk(0, 0, 0, 0,   0, 0, 10,  240, 0, 0, 0, 0, 0);
        vecs[11] = mk(0, 0, 0, 0,   0, 0, 320, 240, 1, 0, 0, 0, 0);

        clear_inputs();
        reset = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_is_dot", is_dot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_tick", frame_tick, 0);
        chk("rst_commit_done", commit_done, 0);
        chk("rst_wr_err", wr_err, 0);
        reset = 1;

        for (int i = 0; i < 12; i++) begin
            dots_wren = vecs[i].wren; dot_num = vecs[i].num; is_x_change = vecs[i].isx;
            dot_pos_change = vecs[i].pos; commit = vecs[i].cm; screenEnd = vecs[i].se;
            x = vecs[i].px; y = vecs[i].py;
            @(posedge clk); #1;
            cyc++;
            chk($sformatf("vec%0d_is_dot", i), is_dot, vecs[i].e_hit);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            chk($sformatf("vec%0d_frame_tick", i), frame_tick, vecs[i].e_ft);
            chk($sformatf("vec%0d_commit_done", i), commit_done, vecs[i].e_cd);
            chk($sformatf("vec%0d_wr_err", i), wr_err, vecs[i].e_err);
        end

        // clamp, bad index, long wait before the frame end
        do_reset();
        wr(25, 1, 5);
        wr(1, 1, 700);
        commit = 1; tick(); commit = 0;
        x = 10'd639; y = 9'd240;
        repeat (200) tick();
        chk("clamp_before_commit", is_dot, 0);
        screenEnd = 1;
        cd_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 3) screenEnd = 0;
            tick();
            if (commit_done) cd_cnt++;
        end
        chk("commit_done_count", cd_cnt, 1);
        tick();
        chk("clamp_after_commit", is_dot, 1);

        // commit on the edge cycle; screenEnd held for 50 clocks
        wr(7, 1, 33);
        commit = 1; screenEnd = 1;
        ft_cnt = 0; cd_cnt = 0; ft_idx = -1; cd_idx = -1;
        for (int k = 0; k < 50; k++) begin
            tick();
            commit = 0;
            if (frame_tick) begin ft_cnt++; ft_idx = k; end
            if (commit_done) begin cd_cnt++; cd_idx = k; end
        end
        chk("hold_ft_count", ft_cnt, 1);
        chk("hold_cd_count", cd_cnt, 1);
        chk("cd_after_ft", cd_idx - ft_idx, 1);
        screenEnd = 0;
        tick();

        // asynchronous reset while a publish is pending
        wr(5, 1, 5);
        wr(5, 0, 5);
        commit = 1; tick(); commit = 0;
        tick();
        #2;
        reset = 0;
        #1;
        chk("busy_async_reset", busy, 0);
        model_reset();
        @(posedge clk); #1;
        reset = 1;
        screenEnd = 1;
        cd_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (k == 2) screenEnd = 0;
            tick();
            if (commit_done) cd_cnt++;
        end
        chk("no_cd_after_reset", cd_cnt, 0);
        x = 10'd5; y = 9'd5; tick();
        chk("reset_dot_gone", is_dot, 0);
        x = 10'd320; y = 9'd240; tick();
        chk("reset_dot_init", is_dot, 1);

        // randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            int j;
            dots_wren      = ($urandom_range(0, 99) < 30);
            dot_num        = 5'($urandom_range(0, 23));
            is_x_change    = 1'($urandom_range(0, 1));
            dot_pos_change = 10'($urandom_range(0, 1023));
            commit         = ($urandom_range(0, 99) < 5);
            if ($urandom_range(0, 99) < 4) screenEnd = ~screenEnd;
            if ($urandom_range(0, 1) == 1) begin
                j = $urandom_range(0, 19);
                x = 10'(m_ax[j]); y = 9'(m_ay[j]);
            end else begin
                x = 10'($urandom_range(0, 700)); y = 9'($urandom_range(0, 511));
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dot_frame_buffer.md
Name: dot_frame_buffer

Overview:
- Upstream feeder for the VGA display stage.
- Holds a processor-written shadow table of NUM_DOTS dot coordinates and an active table used for drawing.
- Copies shadow to active atomically, only at a frame boundary (screenEnd), so a frame never shows a half-updated set of dots.
- Resolves per-pixel dot hits for the display path and reports frame and commit status back to the processor.

Parameters:
NUM_DOTS, 20, number of dots tracked
IDX_WIDTH, 5, width of dot index (>= clog2(NUM_DOTS))
X_WIDTH, 10, x coordinate width
Y_WIDTH, 9, y coordinate width
X_MAX, 639, largest legal x
Y_MAX, 479, largest legal y
X_INIT, 320, reset x of every dot
Y_INIT, 240, reset y of every dot

Ports:
clk  in  1  100 MHz system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
dots_wren  in  1  processor write strobe, one cycle per write
dot_num  in  IDX_WIDTH  dot index to write
is_x_change  in  1  1 = write x, 0 = write y
dot_pos_change  in  X_WIDTH  new coordinate; y writes use [Y_WIDTH-1:0]
commit  in  1  processor request to publish shadow table at next frame end
screenEnd  in  1  level from timing generator, high between frames
x  in  X_WIDTH  current pixel x
y  in  Y_WIDTH  current pixel y
is_dot  out  1  registered: pixel (x,y) matches an active dot
busy  out  1  commit pending or copy in progress
frame_tick  out  1  one-cycle pulse on every screenEnd rising edge
commit_done  out  1  one-cycle pulse when active table has been updated
wr_err  out  1  sticky: illegal or dropped write since last accepted commit

Behaviour:
- Reset (async, active-low): all shadow/active entries = (X_INIT, Y_INIT); is_dot, busy, frame_tick, commit_done, wr_err = 0; FSM = IDLE; screenEnd edge register = 0.
- screenEnd is sampled into a register each clk; edge = screenEnd & ~screenEnd_q.
- frame_tick = edge, registered, so it is a one-cycle pulse one clk after the edge.
- Writes:
  - A write with dots_wren=1, dot_num < NUM_DOTS and busy=0 updates shadow x or y next cycle.
  - Values above X_MAX / Y_MAX are clamped to the maximum, and wr_err is set.
  - dot_num >= NUM_DOTS: write ignored, wr_err set.
  - Write while busy=1: dropped, wr_err set.
- FSM:
  - IDLE: on commit=1, go to PENDING. If edge=1 in the same cycle, go straight to COPY.
  - PENDING: on edge, go to COPY. commit is ignored here.
  - COPY: one cycle; all active entries <= shadow entries in parallel; pulse commit_done; clear wr_err; return to IDLE.
- busy = (state != IDLE), registered.
- Write and commit in the same cycle: the write is accepted and is included in the copy.
- No commit pending at edge: active table unchanged; frame_tick only.
- is_dot: one clk latency. is_dot <= OR over i of (x == active_x[i] && y == active_y[i]). Duplicate dots still produce a single 1.
- Reset mid-PENDING or mid-COPY: FSM returns to IDLE and both tables return to init values; no commit_done is emitted.

Decomposition:
- Shared package: NUM_DOTS, IDX_WIDTH, X_WIDTH, Y_WIDTH, X_MAX, Y_MAX, X_INIT, Y_INIT, and the FSM state encoding (IDLE=2'd0, PENDING=2'd1, COPY=2'd2).
- One sub-module: dot_hit_compare. Combinational OR-reduction of NUM_DOTS coordinate comparators; its output is registered into is_dot in the parent.

Test Plan:
- Reset release; drive x=320, y=240 -> is_dot=1 next clk. Drive x=321 -> is_dot=0. busy=0, wr_err=0.
- Write dot 3 x=100, y=50, then commit; pulse screenEnd after 200 clks -> commit_done pulses exactly once. Before the pulse, (100,50) gives is_dot=0; after, is_dot=1.
- While busy=1, write dot 0 x=10 -> wr_err=1 and shadow unchanged. After the commit, dot 0 is still at (320,240).
- Write dot_num=25 -> ignored, wr_err=1. Write x=700 to dot 1 -> clamped to 639. After commit, (639,240) gives is_dot=1.
- commit in the same cycle as the screenEnd rising edge -> COPY on the next cycle, commit_done 2 clks after the edge. screenEnd held high 50 clks -> only one frame_tick.
- Assert reset while PENDING -> busy=0 immediately. The next screenEnd edge produces no commit_done, and all dots read back at (320,240).
